// File: rtl/sao_stat_ctb_acc.sv
// Per-category SAO statistics accumulator for one CTB: sums 4-pixel diff partials and hit counts.
// Optional macro SAO_STAT_ACC_SAT_EN: saturate sums instead of two's-complement wrap.
module sao_stat_ctb_acc #(
    parameter int diff_clip_bit = 4,
    parameter int n_cate        = 5,
    parameter int acc_bit       = 18,
    parameter int cnt_bit       = 13
) (
    input  logic                             clk,
    input  logic                             arst_n,
    input  logic                             ctb_start,
    input  logic                             in_valid,
    input  logic                             in_last,
    input  logic signed [diff_clip_bit+2:0]  s41 [n_cate],
    input  logic        [2:0]                n41 [n_cate],
    output logic                             in_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [acc_bit-1:0]        sum_out [n_cate],
    output logic        [cnt_bit-1:0]        cnt_out [n_cate],
    output logic                             ovf
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t state, state_nxt;
    logic   load;
    logic   acc_en;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        acc_en    = 1'b0;
        case (state)
            IDLE: if (ctb_start) load = 1'b1;
            ACC: begin
                if (ctb_start) begin
                    load = 1'b1;
                end else if (in_valid) begin
                    acc_en = 1'b1;
                    if (in_last) state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                    if (ctb_start) load = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A clear also takes the same-cycle beat as its start value.
        if (load) state_nxt = (in_valid && in_last) ? DONE : ACC;
    end

    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);

    localparam logic signed [acc_bit-1:0] sum_max = {1'b0, {(acc_bit-1){1'b1}}};
    localparam logic signed [acc_bit-1:0] sum_min = {1'b1, {(acc_bit-1){1'b0}}};

    logic signed [acc_bit-1:0] base_s  [n_cate];
    logic signed [acc_bit-1:0] add_s   [n_cate];
    logic signed [acc_bit-1:0] raw_s   [n_cate];
    logic signed [acc_bit-1:0] sum_nxt [n_cate];
    logic        [cnt_bit:0]   raw_c   [n_cate];
    logic        [cnt_bit-1:0] cnt_nxt [n_cate];
    logic                      ovf_hit;
    logic                      ovf_nxt;

    always_comb begin
        ovf_hit = 1'b0;
        for (int i = 0; i < n_cate; i++) begin
            base_s[i]  = load ? '0 : sum_out[i];
            add_s[i]   = in_valid ? acc_bit'(s41[i]) : '0;
            raw_s[i]   = base_s[i] + add_s[i];
            sum_nxt[i] = raw_s[i];
            if ((base_s[i][acc_bit-1] == add_s[i][acc_bit-1]) &&
                (raw_s[i][acc_bit-1] != base_s[i][acc_bit-1])) begin
                ovf_hit = 1'b1;
`ifdef SAO_STAT_ACC_SAT_EN
                sum_nxt[i] = base_s[i][acc_bit-1] ? sum_min : sum_max;
`else
                sum_nxt[i] = raw_s[i];
`endif
            end
            raw_c[i]   = {1'b0, (load ? '0 : cnt_out[i])} + (cnt_bit+1)'(in_valid ? n41[i] : 3'd0);
            cnt_nxt[i] = raw_c[i][cnt_bit-1:0];
            if (raw_c[i][cnt_bit]) begin
                ovf_hit    = 1'b1;
                cnt_nxt[i] = '1;
            end
        end
        ovf_nxt = (ovf && !load) || ovf_hit;
    end

    // NOTE: the accumulators are reset because they drive the outputs directly and must read 0 after reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= IDLE;
            sum_out <= '{default: '0};
            cnt_out <= '{default: '0};
            ovf     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state <= state_nxt;
            if (load || acc_en) begin
                sum_out <= sum_nxt;
                cnt_out <= cnt_nxt;
                ovf     <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sao_stat_ctb_acc.sv
// Directed bench for sao_stat_ctb_acc; a narrow (acc_bit=8, cnt_bit=6) copy exercises overflow paths.
module tb_sao_stat_ctb_acc;

    logic clk = 1'b0;
    logic arst_n;
    logic ctb_start, in_valid, in_last, out_ready;
    logic signed [6:0] s41 [5];
    logic        [2:0] n41 [5];

    logic in_ready, out_valid, ovf;
    logic signed [17:0] sum_out [5];
    logic        [12:0] cnt_out [5];

    logic in_ready8, out_valid8, ovf8;
    logic signed [7:0] sum8 [5];
    logic        [5:0] cnt8 [5];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sao_stat_ctb_acc dut (
        .clk(clk), .arst_n(arst_n), .ctb_start(ctb_start), .in_valid(in_valid),
        .in_last(in_last), .s41(s41), .n41(n41), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
        .cnt_out(cnt_out), .ovf(ovf)
    );

    sao_stat_ctb_acc #(.acc_bit(8), .cnt_bit(6)) dut8 (
        .clk(clk), .arst_n(arst_n), .ctb_start(ctb_start), .in_valid(in_valid),
        .in_last(in_last), .s41(s41), .n41(n41), .in_ready(in_ready8),
        .out_valid(out_valid8), .out_ready(out_ready), .sum_out(sum8),
        .cnt_out(cnt8), .ovf(ovf8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ctb_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s41[i] = '0;
            n41[i] = '0;
        end
    endtask

    task automatic check_zero_all(input string tag);
        for (int i = 0; i < 5; i++) begin
            check({tag, "_sum"}, sum_out[i], 0);
            check({tag, "_cnt"}, cnt_out[i], 0);
        end
    endtask

    initial begin
        out_ready = 1'b0;
        idle_in();
        arst_n = 1'b0;
        #22;
        arst_n = 1'b1;
        tick();

        // Reset state
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_ovf", ovf, 0);
        check_zero_all("rst");

        // 1: four beats of +5/4 on category 0
        ctb_start = 1'b1; tick(); ctb_start = 1'b0;
        check("t1_in_ready", in_ready, 1);
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1; s41[0] = 7'sd5; n41[0] = 3'd4; in_last = (b == 3);
            tick();
            if (b < 3) check("t1_no_out", out_valid, 0);
        end
        idle_in();
        check("t1_out_valid", out_valid, 1);
        check("t1_in_ready", in_ready, 0);
        check("t1_sum0", sum_out[0], 20);
        check("t1_cnt0", cnt_out[0], 16);
        check("t1_sum1", sum_out[1], 0);
        check("t1_cnt4", cnt_out[4], 0);
        check("t1_ovf", ovf, 0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("t1_hs_out_valid", out_valid, 0);

        // 2: start + single last beat in one cycle
        ctb_start = 1'b1; in_valid = 1'b1; in_last = 1'b1; s41[2] = -7'sd7; n41[2] = 3'd3;
        tick(); idle_in();
        check("t2_out_valid", out_valid, 1);
        check("t2_sum2", sum_out[2], -7);
        check("t2_cnt2", cnt_out[2], 3);
        check("t2_sum0", sum_out[0], 0);

        // 3: hold DONE with out_ready low, disturbing inputs
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0]; in_last = 1'b1; s41[2] = 7'sd10; n41[2] = 3'd4;
            ctb_start = (c == 2);
            tick();
            check("t3_out_valid", out_valid, 1);
            check("t3_in_ready", in_ready, 0);
            check("t3_sum2", sum_out[2], -7);
            check("t3_cnt2", cnt_out[2], 3);
        end
        idle_in();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("t3_hs_out_valid", out_valid, 0);
        check("t3_idle_in_ready", in_ready, 0);
        in_valid = 1'b1; in_last = 1'b1; s41[2] = 7'sd9;
        tick(); idle_in();
        check("t3_idle_ignore_ov", out_valid, 0);
        check("t3_idle_ignore_ir", in_ready, 0);
        check("t3_idle_ignore_sum", sum_out[2], -7);

        // 4: abort after three beats, then one +2 last beat
        ctb_start = 1'b1; tick(); ctb_start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1; s41[1] = 7'sd4; n41[1] = 3'd1;
            tick();
        end
        check("t4_mid_sum1", sum_out[1], 12);
        idle_in();
        ctb_start = 1'b1; tick(); ctb_start = 1'b0;
        check("t4_abort_ov", out_valid, 0);
        check("t4_abort_ir", in_ready, 1);
        check("t4_abort_sum1", sum_out[1], 0);
        in_valid = 1'b1; in_last = 1'b1; s41[1] = 7'sd2; n41[1] = 3'd1;
        tick(); idle_in();
        check("t4_out_valid", out_valid, 1);
        check("t4_sum1", sum_out[1], 2);
        check("t4_cnt1", cnt_out[1], 1);
        check("t4_sum2", sum_out[2], 0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // 5: 20 beats of +15/4 on category 0; narrow copy overflows
        ctb_start = 1'b1; tick(); ctb_start = 1'b0;
        for (int b = 0; b < 20; b++) begin
            in_valid = 1'b1; s41[0] = 7'sd15; n41[0] = 3'd4; in_last = (b == 19);
            tick();
        end
        idle_in();
        check("t5_out_valid", out_valid, 1);
        check("t5_out_valid8", out_valid8, 1);
        check("t5_sum0", sum_out[0], 300);
        check("t5_cnt0", cnt_out[0], 80);
        check("t5_ovf", ovf, 0);
`ifdef SAO_STAT_ACC_SAT_EN
        check("t5_sum8", sum8[0], 127);
`else
        check("t5_sum8", sum8[0], 44);
`endif
        check("t5_cnt8_sat", cnt8[0], 63);
        check("t5_ovf8", ovf8, 1);

        // 6: asynchronous reset while in DONE
        #2 arst_n = 1'b0;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_ovf8", ovf8, 0);
        check("t6_sum8", sum8[0], 0);
        check_zero_all("t6");
        #1 arst_n = 1'b1;
        in_valid = 1'b1; in_last = 1'b1; s41[3] = 7'sd6; n41[3] = 3'd2;
        tick(); idle_in();
        check("t6_ignore_ov", out_valid, 0);
        check("t6_ignore_ir", in_ready, 0);
        check("t6_ignore_sum3", sum_out[3], 0);
        ctb_start = 1'b1; in_valid = 1'b1; in_last = 1'b1; s41[3] = -7'sd64; n41[3] = 3'd2;
        tick(); idle_in();
        check("t6_restart_ov", out_valid, 1);
        check("t6_restart_sum3", sum_out[3], -64);
        check("t6_restart_cnt3", cnt_out[3], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sao_stat_ctb_acc.md
Name: sao_stat_ctb_acc

Overview:
Accumulates per-category SAO statistics for one CTB. Each beat carries, per category, a 4-pixel partial diff sum (from the 4-pixel adder stage) and a 4-pixel hit count. The block sits directly downstream of the 4-pixel partial-sum adders. It produces final per-category diff sums and counts for the SAO offset/RDO decision stage, using a valid/ready handshake.

Parameters:
diff_clip_bit, 4, clipped-diff magnitude bits; input partial sum is signed [diff_clip_bit+2:0]
n_cate, 5, number of categories accumulated in parallel
acc_bit, 18, signed accumulator width per category (64x64 CTB, |diff|<=16)
cnt_bit, 13, unsigned count width per category (max 4096)

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
ctb_start  in  1  pulse: clear accumulators and open a CTB
in_valid  in  1  beat valid
in_last  in  1  last beat of CTB (qualified by in_valid)
s41  in  n_cate x [diff_clip_bit+2:0] signed  per-category 4-pixel diff sum
n41  in  n_cate x [2:0]  per-category 4-pixel hit count (0..4)
in_ready  out  1  high when beats are accepted (state ACC)
out_valid  out  1  results valid
out_ready  in  1  consumer accepts results
sum_out  out  n_cate x [acc_bit-1:0] signed  accumulated diff sums
cnt_out  out  n_cate x [cnt_bit-1:0]  accumulated counts
ovf  out  1  sticky: any accumulator saturated/wrapped this CTB

Behaviour:
- Single clock domain: clk, with asynchronous active-low reset arst_n. On reset: state=IDLE; in_ready=0; out_valid=0; all sum_out, cnt_out and ovf = 0.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - ctb_start -> ACC. Accumulators and ovf clear.
  - If in_valid is high in the same cycle, that beat is loaded (start value = beat value). If it also carries in_last, the next state is DONE.
  - in_valid without ctb_start is ignored.
- ACC:
  - in_ready=1.
  - in_valid: sum[i] += sign-extended s41[i]; cnt[i] += n41[i].
  - in_valid & in_last: the beat is accumulated, then the next state is DONE.
  - ctb_start in ACC aborts the CTB: accumulators clear (same-cycle beat loaded as in IDLE) and the state stays ACC. No output is produced for the aborted CTB.
- DONE:
  - out_valid=1 and in_ready=0. sum_out, cnt_out and ovf are held stable.
  - out_valid & out_ready -> IDLE. out_valid drops the next cycle.
  - A ctb_start in the same cycle as the handshake opens the next CTB (-> ACC, clear/load as above).
  - A ctb_start without out_ready is ignored. in_valid is ignored.
- Latency: out_valid rises the cycle after the in_last beat is accepted.
- sum_out/cnt_out are the accumulator registers directly, with no extra stage.
- Accumulators are register-only, with no combinational path from s41 to outputs.
- Arithmetic: count accumulation is unsigned. cnt overflow sets ovf and saturates at all-ones.
- Sum behaviour on overflow is defined under the optional feature. ovf is sticky until the next clear.
- Reset mid-operation: asserting arst_n in any state returns to the reset values immediately.

Optional Feature:
Macro SAO_STAT_ACC_SAT_EN.
- Defined: each sum saturates at +(2^(acc_bit-1)-1) / -(2^(acc_bit-1)). Saturation sets ovf.
- Undefined: sums wrap two's-complement. ovf is set on signed overflow (operand signs equal, result sign differs).
- Count saturation is the same in both builds.

Test Plan:
1. Reset, then ctb_start, then 4 beats with s41[0]=+5 and n41[0]=4, in_last on beat 4 -> next cycle out_valid=1, sum_out[0]=20, cnt_out[0]=16, other categories 0, ovf=0.
2. Same cycle ctb_start+in_valid+in_last with s41[2]=-7 and n41[2]=3 -> DONE next cycle, sum_out[2]=-7, cnt_out[2]=3.
3. DONE with out_ready=0 for 5 cycles while in_valid toggles -> outputs stable, in_ready=0. Then out_ready=1 -> out_valid=0 next cycle, state IDLE.
4. Mid-CTB ctb_start after 3 beats of s41[1]=+4, then 1 beat of +2 with in_last -> sum_out[1]=2, no output for the aborted CTB.
5. With acc_bit=8, 20 beats of s41[0]=+15 -> SAT_EN build: sum_out[0]=127, ovf=1. Non-SAT build: sum_out[0]=300 mod 256 as signed = 44, ovf=1.
6. Assert arst_n low in DONE -> out_valid, sum_out, cnt_out and ovf all 0 immediately, and in_valid is ignored until the next ctb_start.
